button_input: RTL and testbench

Debounced push-button front end for the board: the input-side counterpart of the seven-segment display path. It synchronizes N raw buttons, debounces each one, and emits registered level, press and release signals in the single clock domain. An optional auto-repeat feature is enabled per button. Its outputs drive user-facing control such as single-stepping the pipeline, selecting which register pair is shown on the display, and incrementing an entry value.

---
 rtl/button_input_if.sv | 30 +++
 rtl/button_input.sv | 171 +++++++++++++++++
 tb/tb_button_input.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/button_input_if.sv
// button_input_if
//   Groups the button-side signals of button_input into one bundle.
//   Btn        raw asynchronous button levels, 1 = pressed
//   RepeatEn   per-channel auto-repeat enable
//   Level      debounced button state
//   Pressed    one-cycle pulse on accepted press and on each auto-repeat
//   Released   one-cycle pulse on accepted release
//   AnyPressed OR of Pressed, same cycle
//   master: the side that drives the buttons (board / bench)
//   slave : button_input itself
interface button_input_if #(
    parameter int N = 5
);
    logic [N-1:0] Btn;
    logic [N-1:0] RepeatEn;
    logic [N-1:0] Level;
    logic [N-1:0] Pressed;
    logic [N-1:0] Released;
    logic         AnyPressed;

    modport master (
        output Btn, RepeatEn,
        input  Level, Pressed, Released, AnyPressed
    );

    modport slave (
        input  Btn, RepeatEn,
        output Level, Pressed, Released, AnyPressed
    );
endinterface

// File: rtl/button_input.sv
// button_input
//   Debounced push-button front end. Each of N raw buttons is passed through
//   a two-flop synchronizer, debounced by a consecutive-agreement counter,
//   and optionally auto-repeated while held. All outputs are registered.
//   i_clk   : single clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : button_input_if.slave (Btn, RepeatEn in; Level, Pressed,
//             Released, AnyPressed out)

// button_chan
//   One button channel: synchronizer, debounce counter, hold/repeat FSM.
//   o_press_nxt is the value Pressed will take at the next edge, exported so
//   the top can register AnyPressed in the same cycle as Pressed.
module button_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    input  logic i_rep_en,
    output logic o_level,
    output logic o_pressed,
    output logic o_released,
    output logic o_press_nxt
);
    typedef enum logic [1:0] {IDLE, FIRST, REPEAT} phase_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_s1, r_s2;
    logic [CNT_W-1:0] r_dcnt, r_hcnt;
    logic             r_level, r_pressed, r_released;
    phase_t           r_state;

    logic [CNT_W-1:0] w_dcnt_nxt, w_hcnt_nxt;
    logic             w_rise, w_fall, w_rep;
    phase_t           w_state_nxt;

    always_comb begin
        w_dcnt_nxt  = r_dcnt + 1'b1;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_rep       = 1'b0;
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;

        // Debounce: any agreeing sample restarts the run of disagreements.
        if (r_s2 == r_level) begin
            w_dcnt_nxt = '0;
        end else if (r_dcnt == DEB_LAST) begin
            w_dcnt_nxt = '0;
            w_rise     = r_s2;
            w_fall     = ~r_s2;
        end

        // Hold/repeat. Accepted edges override counting, so a repeat pulse
        // can never coincide with a press or release of the same channel.
        if (w_fall) begin
            w_state_nxt = IDLE;
            w_hcnt_nxt  = '0;
        end else if (w_rise) begin
            w_state_nxt = FIRST;
            w_hcnt_nxt  = '0;
        end else begin
            case (r_state)
                FIRST: begin
                    if (!i_rep_en) begin
                        w_hcnt_nxt = '0;
                    end else if (r_hcnt == HOLD_LAST) begin
                        w_rep       = 1'b1;
                        w_hcnt_nxt  = '0;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!i_rep_en) begin
                        w_hcnt_nxt = '0;
                    end else if (r_hcnt == REP_LAST) begin
                        w_rep      = 1'b1;
                        w_hcnt_nxt = '0;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_dcnt     <= '0;
            r_hcnt     <= '0;
            r_level    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_state    <= IDLE;
        end else begin
            r_s1       <= i_btn;
            r_s2       <= r_s1;
            r_dcnt     <= w_dcnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_level    <= w_rise ? 1'b1 : (w_fall ? 1'b0 : r_level);
            r_pressed  <= w_rise | w_rep;
            r_released <= w_fall;
            r_state    <= w_state_nxt;
        end
    end

    assign o_level     = r_level;
    assign o_pressed   = r_pressed;
    assign o_released  = r_released;
    // Masked by reset so AnyPressed clears together with Pressed.
    assign o_press_nxt = (w_rise | w_rep) & ~i_reset;
endmodule

module button_input #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic           i_clk,
    input  logic           i_reset,
    button_input_if.slave  bus
);
    logic [N-1:0] w_level, w_pressed, w_released, w_press_nxt;
    logic         r_any;

    for (genvar g = 0; g < N; g++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_btn       (bus.Btn[g]),
            .i_rep_en    (bus.RepeatEn[g]),
            .o_level     (w_level[g]),
            .o_pressed   (w_pressed[g]),
            .o_released  (w_released[g]),
            .o_press_nxt (w_press_nxt[g])
        );
    end

    // Registered from the channels' next-Pressed values: same cycle as Pressed.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_any <= 1'b0;
        else         r_any <= |w_press_nxt;
    end

    assign bus.Level      = w_level;
    assign bus.Pressed    = w_pressed;
    assign bus.Released   = w_released;
    assign bus.AnyPressed = r_any;
endmodule

// File: tb/tb_button_input.sv
module tb_button_input;
    localparam int N = 2;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] pressed;
        logic [N-1:0] released;
        logic         any;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    button_input_if #(.N(N)) bif ();

    button_input #(
        .N(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .CNT_W(8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare the outputs of the edge just passed.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("level",    bif.Level,    e.level);
            chk("pressed",  bif.Pressed,  e.pressed);
            chk("released", bif.Released, e.released);
            chk("any",      {{(N-1){1'b0}}, bif.AnyPressed}, {{(N-1){1'b0}}, e.any});
        end
    end

    // Push the expectation for the next edge, then let it happen.
    task automatic step(input logic [N-1:0] lv, input logic [N-1:0] pr, input logic [N-1:0] rl);
        exp_t e;
        e.level = lv; e.pressed = pr; e.released = rl; e.any = |pr;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.Btn      = '0;
        bif.RepeatEn = '0;
        rst          = 1'b1;
        #2;
        // Reset state
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        step(2'b00, 2'b00, 2'b00);

        // Clean press, no repeat: accepted at edge 5 only
        bif.Btn = 2'b01;
        for (int e = 0; e <= 20; e++)
            step((e >= 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00);

        // Release: Level falls and Released pulses 5 edges after first low sample
        bif.Btn = 2'b00;
        for (int e = 0; e <= 8; e++)
            step((e < 5) ? 2'b01 : 2'b00, 2'b00, (e == 5) ? 2'b01 : 2'b00);

        // Bounce shorter than the debounce window never changes Level
        begin
            logic [4:0] pat;
            pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
            for (int e = 0; e < 5; e++) begin
                bif.Btn = {1'b0, pat[e]};
                step(2'b00, 2'b00, 2'b00);
            end
            bif.Btn = 2'b00;
            for (int e = 0; e < 10; e++) step(2'b00, 2'b00, 2'b00);
        end

        // Auto-repeat: press at 5, then 15, 18, 21, 24
        bif.RepeatEn = 2'b01;
        bif.Btn      = 2'b01;
        for (int e = 0; e <= 25; e++)
            step((e >= 5) ? 2'b01 : 2'b00,
                 (e == 5 || e == 15 || e == 18 || e == 21 || e == 24) ? 2'b01 : 2'b00,
                 2'b00);
        // Dropping RepeatEn stops further pulses
        bif.RepeatEn = 2'b00;
        for (int e = 0; e < 12; e++) step(2'b01, 2'b00, 2'b00);
        bif.Btn = 2'b00;
        for (int e = 0; e <= 6; e++)
            step((e < 5) ? 2'b01 : 2'b00, 2'b00, (e == 5) ? 2'b01 : 2'b00);

        // Simultaneous channels
        bif.Btn = 2'b11;
        for (int e = 0; e <= 8; e++)
            step((e >= 5) ? 2'b11 : 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00);
        bif.Btn = 2'b00;
        for (int e = 0; e <= 6; e++)
            step((e < 5) ? 2'b11 : 2'b00, 2'b00, (e == 5) ? 2'b11 : 2'b00);

        // Reset mid-debounce, button held through it: fresh press afterwards
        bif.Btn = 2'b01;
        for (int e = 0; e < 3; e++) step(2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        step(2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int e = 0; e <= 8; e++)
            step((e >= 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00);
        bif.Btn = 2'b00;
        for (int e = 0; e <= 6; e++)
            step((e < 5) ? 2'b01 : 2'b00, 2'b00, (e == 5) ? 2'b01 : 2'b00);

        #10;
        n_checks++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
